core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high; sampled on rising Clk edge.
REQ-003 Start  input  1  testbench run request; level, high one or more cycles.
REQ-004 Ack  input  1  decoded halt instruction (all-ones opcode).
REQ-005 LoadInst  input  1  decoded load.
REQ-006 MemWrEn  input  1  decoded store.
REQ-007 RegWrEn  input  1  decoded register write.
REQ-008 Branch  input  1  decoded absolute branch.
REQ-009 BranchEn  input  1  decoded relative branch.
REQ-010 CondFlag  input  1  ALU condition flag qualifying relative branch.
REQ-011 PCReset  output  1  forces program counter to 0.
REQ-012 PCEn  output  1  program counter advances (increment or load).
REQ-013 PCLoad  output  1  program counter takes branch target instead of +1.
REQ-014 RegWrGated  output  1  register-file write enable after sequencing.
REQ-015 MemWrGated  output  1  data-memory write enable after sequencing.
REQ-016 Done  output  1  program finished; held until next Start.
REQ-017 CycleCount  output  16  cycles spent in RUN/LOAD_WAIT.

Function
REQ-018 States SHALL be IDLE, PRIME, RUN, LOAD_WAIT, HALT; encoding free.
REQ-019 IDLE: Start=1 -> PRIME; else stay; all outputs 0 except Done held from previous HALT.
REQ-020 PRIME: PCReset=1, Done=0, CycleCount cleared to 0; stay while Start=1; Start=0 -> RUN.
REQ-021 RUN: PCEn=1 unless Ack=1 or LoadInst=1; RegWrGated=RegWrEn&~Ack&~LoadInst; MemWrGated=MemWrEn&~Ack.
REQ-022 RUN, LoadInst=1 -> LOAD_WAIT; PCEn=0 and RegWrGated=0 that cycle.
REQ-023 LOAD_WAIT: exactly one cycle; PCEn=1, RegWrGated=1, MemWrGated=0; -> RUN.
REQ-024 PCLoad=PCEn&(Branch|(BranchEn&CondFlag)); relative branch with CondFlag=0 increments normally.
REQ-025 RUN, Ack=1 -> HALT; Ack priority over LoadInst, MemWrEn, branches: no PC move, no writes that cycle.
REQ-026 HALT: Done=1, PCEn=0, writes 0; Start=1 -> PRIME; Done stays 1 in HALT and in IDLE, cleared only in PRIME.
REQ-027 Start=1 while in RUN or LOAD_WAIT SHALL abort to PRIME next cycle; in-flight load write suppressed.
REQ-028 All outputs except CycleCount and Done SHALL be combinational from state and decoded inputs; zero added latency.
REQ-029 CycleCount increments by 1 each cycle in RUN or LOAD_WAIT; saturates at 16'hFFFF, no wrap.
REQ-030 CycleCount holds value in HALT and IDLE until next PRIME.

Reset
REQ-031 Reset=1 SHALL force IDLE next edge, CycleCount=0, Done=0, regardless of current state, including mid-load.
REQ-032 During Reset cycle all outputs SHALL be 0; Start sampled in the same cycle as Reset is ignored.

Configuration
REQ-033 Macro CORE_SEQUENCER_CYCLE_COUNT_EN defined: CycleCount counter per REQ-029/030.
REQ-034 Macro undefined: no counter flops; CycleCount tied 16'h0000; all other behaviour identical.

Verification
REQ-035 Reset, Start high 3 cycles then low -> PCReset=1 for 3 cycles, RUN next, PCEn=1 each plain instruction.
REQ-036 RUN, LoadInst=1, RegWrEn=1 -> cycle N: PCEn=0, RegWrGated=0; cycle N+1: PCEn=1, RegWrGated=1; then RUN.
REQ-037 BranchEn=1, CondFlag=0 -> PCLoad=0, PCEn=1; CondFlag=1 -> PCLoad=1; Branch=1 -> PCLoad=1 regardless of flag.
REQ-038 Ack=1 with MemWrEn=1 and RegWrEn=1 -> MemWrGated=0, RegWrGated=0, HALT next, Done=1, CycleCount frozen (e.g. 10 after 10 RUN cycles).
REQ-039 Reset asserted in LOAD_WAIT -> IDLE next edge, RegWrGated=0, Done=0, CycleCount=0; Start pulse mid-RUN -> PRIME, PCReset=1.
REQ-040 Counter built: hold RUN 70000 cycles -> CycleCount=16'hFFFF, no wrap; macro undefined -> CycleCount=0 throughout.

Source files
------------

// File: rtl/core_sequencer.sv
// Instruction-level sequencer: primes the PC, gates PC/write enables per instruction, halts on Ack.
// Optional cycle counter enabled by defining CORE_SEQUENCER_CYCLE_COUNT_EN.
module core_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Ack,
    input  logic        LoadInst,
    input  logic        MemWrEn,
    input  logic        RegWrEn,
    input  logic        Branch,
    input  logic        BranchEn,
    input  logic        CondFlag,
    output logic        PCReset,
    output logic        PCEn,
    output logic        PCLoad,
    output logic        RegWrGated,
    output logic        MemWrGated,
    output logic        Done,
    output logic [15:0] CycleCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_LOAD_WAIT,
        S_HALT
    } state_e;

    state_e state_q, state_d;
    logic   done_q, done_d;
    logic   pc_reset, pc_en, reg_wr, mem_wr;

    always_comb begin
        state_d  = state_q;
        pc_reset = 1'b0;
        pc_en    = 1'b0;
        reg_wr   = 1'b0;
        mem_wr   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_PRIME;
            end
            S_PRIME: begin
                pc_reset = 1'b1;
                if (!Start) state_d = S_RUN;
            end
            S_RUN: begin
                pc_en  = ~Ack & ~LoadInst;
                reg_wr = RegWrEn & ~Ack & ~LoadInst;
                mem_wr = MemWrEn & ~Ack;
                if (Start)         state_d = S_PRIME;
                else if (Ack)      state_d = S_HALT;
                else if (LoadInst) state_d = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                // An abort arriving here drops the pending load write-back.
                if (Start) begin
                    state_d = S_PRIME;
                end else begin
                    pc_en   = 1'b1;
                    reg_wr  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
                if (Start) state_d = S_PRIME;
            end
            default: state_d = S_IDLE;
        endcase

        if (Reset) begin
            state_d  = S_IDLE;
            pc_reset = 1'b0;
            pc_en    = 1'b0;
            reg_wr   = 1'b0;
            mem_wr   = 1'b0;
        end
    end

    always_comb begin
        done_d = done_q;
        if (state_d == S_HALT)       done_d = 1'b1;
        else if (state_d == S_PRIME) done_d = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign PCReset    = pc_reset;
    assign PCEn       = pc_en;
    assign PCLoad     = pc_en & (Branch | (BranchEn & CondFlag));
    assign RegWrGated = reg_wr;
    assign MemWrGated = mem_wr;
    assign Done       = done_q & ~Reset;

`ifdef CORE_SEQUENCER_CYCLE_COUNT_EN
    logic [15:0] count_q, count_d;

    // Cleared on entry to PRIME so the count already reads 0 during PRIME.
    always_comb begin
        count_d = count_q;
        if (state_d == S_PRIME)
            count_d = '0;
        else if ((state_q == S_RUN || state_q == S_LOAD_WAIT) && count_q != 16'hFFFF)
            count_d = count_q + 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign CycleCount = Reset ? '0 : count_q;
`else
    assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: driver queues expected outputs per cycle, monitor compares at negedge.
module tb_core_sequencer;

    logic        Clk = 1'b0;
    logic        Reset, Start, Ack, LoadInst, MemWrEn, RegWrEn, Branch, BranchEn, CondFlag;
    logic        PCReset, PCEn, PCLoad, RegWrGated, MemWrGated, Done;
    logic [15:0] CycleCount;

    core_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Ack        (Ack),
        .LoadInst   (LoadInst),
        .MemWrEn    (MemWrEn),
        .RegWrEn    (RegWrEn),
        .Branch     (Branch),
        .BranchEn   (BranchEn),
        .CondFlag   (CondFlag),
        .PCReset    (PCReset),
        .PCEn       (PCEn),
        .PCLoad     (PCLoad),
        .RegWrGated (RegWrGated),
        .MemWrGated (MemWrGated),
        .Done       (Done),
        .CycleCount (CycleCount)
    );

    always #5 Clk = ~Clk;

    string       name_q[$];
    logic [21:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [15:0] ec(input int c);
`ifdef CORE_SEQUENCER_CYCLE_COUNT_EN
        ec = (c > 65535) ? 16'hFFFF : c[15:0];
`else
        ec = 16'h0000;
`endif
    endfunction

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            string       nm;
            logic [21:0] ex, act;
            nm  = name_q.pop_front();
            ex  = exp_q.pop_front();
            act = {PCReset, PCEn, PCLoad, RegWrGated, MemWrGated, Done, CycleCount};
            n_checks++;
            if (act !== ex) begin
                n_fail++;
                $display("FAIL %s: got {pcr,pcen,pcl,rwg,mwg,done}=%b cnt=%0d, expected %b cnt=%0d",
                         nm, act[21:16], act[15:0], ex[21:16], ex[15:0]);
            end
        end
    end

    // in = {Reset,Start,Ack,LoadInst,MemWrEn,RegWrEn,Branch,BranchEn,CondFlag}
    // ex = {PCReset,PCEn,PCLoad,RegWrGated,MemWrGated,Done}
    task automatic cyc(input string nm, input logic [8:0] in, input logic [5:0] ex,
                       input int cnt, input bit chk);
        {Reset, Start, Ack, LoadInst, MemWrEn, RegWrEn, Branch, BranchEn, CondFlag} = in;
        if (chk) begin
            name_q.push_back(nm);
            exp_q.push_back({ex, ec(cnt)});
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        {Reset, Start, Ack, LoadInst, MemWrEn, RegWrEn, Branch, BranchEn, CondFlag} = '0;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        //             name            RSALMWBEC      pcr..done cnt
        cyc("reset_start",  9'b110000000, 6'b000000, 0,  1);
        cyc("reset",        9'b100000000, 6'b000000, 0,  1);
        cyc("idle",         9'b000000000, 6'b000000, 0,  1);
        cyc("idle_start",   9'b010000000, 6'b000000, 0,  1);
        cyc("prime1",       9'b010000000, 6'b100000, 0,  1);
        cyc("prime2",       9'b010000000, 6'b100000, 0,  1);
        cyc("prime3",       9'b000000000, 6'b100000, 0,  1);
        cyc("run_regwr",    9'b000001000, 6'b010100, 0,  1);
        cyc("run_store",    9'b000010000, 6'b010010, 1,  1);
        cyc("run_load",     9'b000101000, 6'b000000, 2,  1);
        cyc("load_wait",    9'b000000000, 6'b010100, 3,  1);
        cyc("rel_br_nf",    9'b000000010, 6'b010000, 4,  1);
        cyc("rel_br_f",     9'b000000011, 6'b011000, 5,  1);
        cyc("abs_br",       9'b000000100, 6'b011000, 6,  1);
        cyc("load_w_br",    9'b000100100, 6'b000000, 7,  1);
        cyc("lw_store_in",  9'b000010000, 6'b010100, 8,  1);
        cyc("ack_priority", 9'b001111100, 6'b000000, 9,  1);
        cyc("halt",         9'b000000000, 6'b000001, 10, 1);
        cyc("halt_writes",  9'b000011000, 6'b000001, 10, 1);
        cyc("halt_start",   9'b010000000, 6'b000001, 10, 1);
        cyc("reprime",      9'b000000000, 6'b100000, 0,  1);
        cyc("run2",         9'b000001000, 6'b010100, 0,  1);
        cyc("run2_load",    9'b000101000, 6'b000000, 1,  1);
        cyc("lw_abort",     9'b010000000, 6'b000000, 2,  1);
        cyc("abort_prime",  9'b000000000, 6'b100000, 0,  1);
        cyc("run_abort",    9'b010001000, 6'b010100, 0,  1);
        cyc("abort_prime2", 9'b000000000, 6'b100000, 0,  1);
        cyc("run3_load",    9'b000100000, 6'b000000, 0,  1);
        cyc("lw_reset",     9'b100000000, 6'b000000, 0,  1);
        cyc("post_reset",   9'b000000000, 6'b000000, 0,  1);

        cyc("sat_start",    9'b010000000, 6'b000000, 0,  1);
        cyc("sat_prime",    9'b000000000, 6'b100000, 0,  1);
        for (int i = 0; i < 70000; i++) begin
            bit chk;
            chk = (i % 4096 == 0) || (i >= 65533 && i <= 65538) || (i == 69999);
            cyc("sat_run", 9'b000000000, 6'b010000, i, chk);
        end
        cyc("sat_halt_ack", 9'b001000000, 6'b000000, 70000, 1);
        cyc("sat_halt",     9'b000000000, 6'b000001, 70001, 1);

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge Clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
